fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the pipelined CPU. Holds the program counter, drives the instruction-memory address, selects the next PC among sequential, branch and jump targets, and latches the fetched word into the decode stage. Its decode-side outputs (`op_d`, `funct_d`, register fields) feed the decode-stage `controller` and register file. It also accepts stall and flush requests from the hazard unit.

---
 rtl/lib_cpu_pkg.sv | 27 ++
 rtl/pipe_reg.sv | 25 ++
 rtl/fetch_stage.sv | 92 +++++++++
 tb/tb_fetch_stage.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/lib_cpu_pkg.sv
// Shared CPU types and constants used across pipeline stages.
package lib_cpu;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned OP_W      = 6;
  localparam int unsigned FUNCT_W   = 6;

  typedef logic [OP_W-1:0]    OPECODE;
  typedef logic [FUNCT_W-1:0] FUNCT;

  localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_RESET_DEFAULT = 32'h0000_0000;

  // IF/ID pipeline register payload
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } ifid_t;

  // J-type target: upper PC nibble, 26-bit index, word aligned
  function automatic logic [XLEN-1:0] jump_target(input logic [XLEN-1:0] pc_plus4,
                                                  input logic [XLEN-1:0] instr);
    return {pc_plus4[31:28], instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: async active-low reset, enable, synchronous clear.
module pipe_reg #(
  parameter int unsigned   W       = 32,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear takes priority over a held (disabled) register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC select, and IF/ID pipeline register.
module fetch_stage
  import lib_cpu::*;
#(
  parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        pc_src_d,
  input  logic        jmp_d,
  input  logic [31:0] pc_branch_d,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output OPECODE      op_d,
  output FUNCT        funct_d,
  output logic [4:0]  rs_d,
  output logic [4:0]  rt_d,
  output logic [4:0]  rd_d,
  output logic [15:0] imm_d
);

  localparam int unsigned IFID_W = $bits(ifid_t);

  logic [31:0] pc_plus4_f;
  logic [31:0] pc_next;
  ifid_t       ifid_in;
  ifid_t       ifid_q;

  assign pc_plus4_f = pc_f + 32'd4;

  // Jump outranks branch; both outrank sequential fetch
  always_comb begin
    pc_next = pc_plus4_f;
    if (jmp_d) begin
      pc_next = jump_target(pc_plus4_d, instr_d);
    end else if (pc_src_d) begin
      pc_next = pc_branch_d;
    end
  end

  pipe_reg #(
    .W       (32),
    .RST_VAL (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (!stall_f),
    .clr   (1'b0),
    .d     (pc_next),
    .q     (pc_f)
  );

  always_comb begin
    ifid_in          = '0;
    ifid_in.instr    = imem_rdata;
    ifid_in.pc_plus4 = pc_plus4_f;
    ifid_in.valid    = 1'b1;
  end

  // Flush clears to a nop bubble, which is also the reset image
  pipe_reg #(
    .W       (IFID_W),
    .RST_VAL ('0)
  ) u_ifid_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (!stall_d),
    .clr   (flush_d),
    .d     (ifid_in),
    .q     (ifid_q)
  );

  assign imem_addr  = pc_f;
  assign instr_d    = ifid_q.instr;
  assign pc_plus4_d = ifid_q.pc_plus4;
  assign valid_d    = ifid_q.valid;

  assign op_d    = OPECODE'(instr_d[31:26]);
  assign funct_d = FUNCT'(instr_d[5:0]);
  assign rs_d    = instr_d[25:21];
  assign rt_d    = instr_d[20:16];
  assign rd_d    = instr_d[15:11];
  assign imm_d   = instr_d[15:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
module tb_fetch_stage;
  import lib_cpu::*;

  logic        clk;
  logic        rst_n;
  logic        stall_f, stall_d, flush_d, pc_src_d, jmp_d;
  logic [31:0] pc_branch_d;
  logic [31:0] imem_addr, imem_rdata, pc_f, instr_d, pc_plus4_d;
  logic        valid_d;
  OPECODE      op_d;
  FUNCT        funct_d;
  logic [4:0]  rs_d, rt_d, rd_d;
  logic [15:0] imm_d;

  logic [31:0] w_imem_addr, w_imem_rdata, w_pc_f, w_instr_d, w_pc_plus4_d;
  logic        w_valid_d;
  OPECODE      w_op_d;
  FUNCT        w_funct_d;
  logic [4:0]  w_rs_d, w_rt_d, w_rd_d;
  logic [15:0] w_imm_d;

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] imem_fn(input logic [31:0] a);
    case (a)
      32'h1000_0004: return 32'h0800_0010;
      32'h0000_0044: return 32'h012A_5820;
      default:       return a >> 2;
    endcase
  endfunction

  always_comb imem_rdata   = imem_fn(imem_addr);
  always_comb w_imem_rdata = imem_fn(w_imem_addr);

  fetch_stage u_dut (
    .clk(clk), .rst_n(rst_n), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .pc_src_d(pc_src_d), .jmp_d(jmp_d), .pc_branch_d(pc_branch_d),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc_f(pc_f), .instr_d(instr_d),
    .pc_plus4_d(pc_plus4_d), .valid_d(valid_d), .op_d(op_d), .funct_d(funct_d),
    .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d), .imm_d(imm_d)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n), .stall_f(1'b0), .stall_d(1'b0), .flush_d(1'b0),
    .pc_src_d(1'b0), .jmp_d(1'b0), .pc_branch_d(32'h0),
    .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata), .pc_f(w_pc_f), .instr_d(w_instr_d),
    .pc_plus4_d(w_pc_plus4_d), .valid_d(w_valid_d), .op_d(w_op_d), .funct_d(w_funct_d),
    .rs_d(w_rs_d), .rt_d(w_rt_d), .rd_d(w_rd_d), .imm_d(w_imm_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ctrl();
    stall_f = 0; stall_d = 0; flush_d = 0; pc_src_d = 0; jmp_d = 0; pc_branch_d = 32'h0;
  endtask

  task automatic test_reset();
    idle_ctrl();
    rst_n = 0;
    #12;
    total++; if (pc_f !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc_f, 32'h0); end
    total++; if (instr_d !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=%h", instr_d, 32'h0); end
    total++; if (pc_plus4_d !== 32'h0) begin bad++; $display("FAIL reset_pc4 got=%h exp=%h", pc_plus4_d, 32'h0); end
    total++; if (valid_d !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_d); end
    total++; if (w_pc_f !== 32'hFFFF_FFFC) begin bad++; $display("FAIL reset_wrap_pc got=%h exp=%h", w_pc_f, 32'hFFFF_FFFC); end
    @(negedge clk);
    rst_n = 1;
    step();
    total++; if (pc_f !== 32'h4) begin bad++; $display("FAIL first_pc got=%h exp=%h", pc_f, 32'h4); end
    total++; if (valid_d !== 1'b1) begin bad++; $display("FAIL first_valid got=%b exp=1", valid_d); end
    total++; if (pc_plus4_d !== 32'h4) begin bad++; $display("FAIL first_pc4 got=%h exp=%h", pc_plus4_d, 32'h4); end
    total++; if (w_pc_f !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%h exp=%h", w_pc_f, 32'h0); end
    total++; if (w_instr_d !== 32'h3FFF_FFFF) begin bad++; $display("FAIL wrap_instr got=%h exp=%h", w_instr_d, 32'h3FFF_FFFF); end
  endtask

  task automatic test_free_run();
    for (int n = 2; n <= 4; n++) begin
      step();
      total++; if (pc_f !== 32'(4*n)) begin bad++; $display("FAIL run_pc n=%0d got=%h exp=%h", n, pc_f, 32'(4*n)); end
      total++; if (instr_d !== 32'(n-1)) begin bad++; $display("FAIL run_instr n=%0d got=%h exp=%h", n, instr_d, 32'(n-1)); end
      total++; if (pc_plus4_d !== 32'(4*n)) begin bad++; $display("FAIL run_pc4 n=%0d got=%h exp=%h", n, pc_plus4_d, 32'(4*n)); end
    end
  endtask

  task automatic test_stall();
    stall_f = 1; stall_d = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      total++; if (pc_f !== 32'h10) begin bad++; $display("FAIL stall_pc c=%0d got=%h exp=%h", c, pc_f, 32'h10); end
      total++; if (instr_d !== 32'h3) begin bad++; $display("FAIL stall_instr c=%0d got=%h exp=%h", c, instr_d, 32'h3); end
    end
    idle_ctrl();
    step();
    total++; if (pc_f !== 32'h14) begin bad++; $display("FAIL unstall_pc got=%h exp=%h", pc_f, 32'h14); end
    total++; if (instr_d !== 32'h4) begin bad++; $display("FAIL unstall_instr got=%h exp=%h", instr_d, 32'h4); end
    step();
    total++; if (instr_d !== 32'h5) begin bad++; $display("FAIL unstall_next got=%h exp=%h", instr_d, 32'h5); end
  endtask

  task automatic test_branch();
    pc_src_d = 1; pc_branch_d = 32'h40; flush_d = 1;
    step();
    idle_ctrl();
    total++; if (pc_f !== 32'h40) begin bad++; $display("FAIL br_pc got=%h exp=%h", pc_f, 32'h40); end
    total++; if (instr_d !== 32'h0) begin bad++; $display("FAIL br_bubble_instr got=%h exp=0", instr_d); end
    total++; if (valid_d !== 1'b0) begin bad++; $display("FAIL br_bubble_valid got=%b exp=0", valid_d); end
    total++; if (pc_plus4_d !== 32'h0) begin bad++; $display("FAIL br_bubble_pc4 got=%h exp=0", pc_plus4_d); end
    step();
    total++; if (instr_d !== 32'h10) begin bad++; $display("FAIL br_target_instr got=%h exp=%h", instr_d, 32'h10); end
    total++; if (valid_d !== 1'b1) begin bad++; $display("FAIL br_target_valid got=%b exp=1", valid_d); end
    step();
    total++; if (op_d !== 6'h00) begin bad++; $display("FAIL field_op got=%h exp=0", op_d); end
    total++; if (rs_d !== 5'd9) begin bad++; $display("FAIL field_rs got=%0d exp=9", rs_d); end
    total++; if (rt_d !== 5'd10) begin bad++; $display("FAIL field_rt got=%0d exp=10", rt_d); end
    total++; if (rd_d !== 5'd11) begin bad++; $display("FAIL field_rd got=%0d exp=11", rd_d); end
    total++; if (funct_d !== 6'h20) begin bad++; $display("FAIL field_funct got=%h exp=20", funct_d); end
    total++; if (imm_d !== 16'h5820) begin bad++; $display("FAIL field_imm got=%h exp=5820", imm_d); end
  endtask

  task automatic test_jump(input logic with_branch);
    pc_src_d = 1; pc_branch_d = 32'h1000_0004; flush_d = 1;
    step();
    idle_ctrl();
    step();
    total++; if (instr_d !== 32'h0800_0010) begin bad++; $display("FAIL jmp_setup_instr got=%h exp=%h", instr_d, 32'h0800_0010); end
    total++; if (pc_plus4_d !== 32'h1000_0008) begin bad++; $display("FAIL jmp_setup_pc4 got=%h exp=%h", pc_plus4_d, 32'h1000_0008); end
    total++; if (op_d !== 6'h02) begin bad++; $display("FAIL jmp_setup_op got=%h exp=02", op_d); end
    jmp_d = 1; flush_d = 1;
    if (with_branch) begin pc_src_d = 1; pc_branch_d = 32'h40; end
    step();
    idle_ctrl();
    total++; if (pc_f !== 32'h1000_0040) begin bad++; $display("FAIL jmp_pc br=%b got=%h exp=%h", with_branch, pc_f, 32'h1000_0040); end
    total++; if (valid_d !== 1'b0) begin bad++; $display("FAIL jmp_bubble br=%b got=%b exp=0", with_branch, valid_d); end
  endtask

  task automatic test_flush_stall();
    step();
    total++; if (instr_d !== 32'h0400_0010) begin bad++; $display("FAIL fs_pre_instr got=%h exp=%h", instr_d, 32'h0400_0010); end
    flush_d = 1; stall_d = 1;
    step();
    idle_ctrl();
    total++; if (valid_d !== 1'b0) begin bad++; $display("FAIL fs_valid got=%b exp=0", valid_d); end
    total++; if (instr_d !== 32'h0) begin bad++; $display("FAIL fs_instr got=%h exp=0", instr_d); end
    total++; if (pc_f !== 32'h1000_0048) begin bad++; $display("FAIL fs_pc got=%h exp=%h", pc_f, 32'h1000_0048); end
  endtask

  task automatic test_stall_f_branch();
    stall_f = 1; stall_d = 1; pc_src_d = 1; pc_branch_d = 32'h80;
    step();
    idle_ctrl();
    total++; if (pc_f !== 32'h1000_0048) begin bad++; $display("FAIL sfb_pc got=%h exp=%h", pc_f, 32'h1000_0048); end
    step();
    total++; if (pc_f !== 32'h1000_004C) begin bad++; $display("FAIL sfb_resume_pc got=%h exp=%h", pc_f, 32'h1000_004C); end
    total++; if (instr_d !== 32'h0400_0012) begin bad++; $display("FAIL sfb_resume_instr got=%h exp=%h", instr_d, 32'h0400_0012); end
  endtask

  task automatic test_async_reset();
    #3;
    rst_n = 0;
    #1;
    total++; if (pc_f !== 32'h0) begin bad++; $display("FAIL areset_pc got=%h exp=0", pc_f); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL areset_addr got=%h exp=0", imem_addr); end
    total++; if (instr_d !== 32'h0) begin bad++; $display("FAIL areset_instr got=%h exp=0", instr_d); end
    total++; if (valid_d !== 1'b0) begin bad++; $display("FAIL areset_valid got=%b exp=0", valid_d); end
    total++; if (pc_plus4_d !== 32'h0) begin bad++; $display("FAIL areset_pc4 got=%h exp=0", pc_plus4_d); end
    @(negedge clk);
    rst_n = 1;
    step();
    total++; if (pc_f !== 32'h4) begin bad++; $display("FAIL areset_restart_pc got=%h exp=%h", pc_f, 32'h4); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_branch();
    test_jump(1'b0);
    test_jump(1'b1);
    test_flush_stall();
    test_stall_f_branch();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
